// File: rtl/disp_arbiter.sv
// ---------------------------------------------------------------------------
// disp_arbiter
// Four-digit multiplexed seven-segment display arbiter. The display normally
// shows the hex digits supplied by the entry FSM. A level request on msg_req
// replaces them with one of four fixed status messages for HOLD_FRAMES scan
// frames. A new request preempts the message that is currently shown.
//
// Optional build macro:
//   DISP_BLINK_EN - while a message is shown, blank all digit enables
//                   whenever hold-counter bit BLINK_SHIFT is set.
//                   Scanning and frame counting continue while blanked.
//
// Outputs an, seg and dp are active-low. Segment order is {g,f,e,d,c,b,a}.
// ---------------------------------------------------------------------------
module disp_arbiter #(
    parameter int SCAN_DIV    = 25000,
    parameter int HOLD_FRAMES = 500,
    parameter int BLINK_SHIFT = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] entry_data,
    input  logic [3:0]  entry_blank,
    input  logic        msg_req,
    input  logic [1:0]  msg_code,
    output logic        msg_ack,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // Slot counter width. SCAN_DIV is at least 2.
    localparam int SCAN_W      = $clog2(SCAN_DIV);
    // The hold counter has to reach HOLD_FRAMES-1.
    localparam int HOLD_BASE_W = $clog2(HOLD_FRAMES + 1);
`ifdef DISP_BLINK_EN
    // The blink phase bit must exist inside the hold counter.
    localparam int HOLD_W = (HOLD_BASE_W > BLINK_SHIFT) ? HOLD_BASE_W : (BLINK_SHIFT + 1);
`else
    localparam int HOLD_W = HOLD_BASE_W;
`endif

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [6:0]        SEG_OFF   = 7'h7F;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_MSG   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [1:0]          k_q, k_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          code_q, code_d;
    logic                ack_q, ack_d;
    logic                busy_q;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q;

    logic                scan_wrap_s;
    logic                frame_end_s;
    logic [3:0]          nibble_s;
    logic [1:0]          char_pos_s;
    logic                blink_off_s;

    // Active-low hex glyph 0-F.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Active-low glyph of character pos (0 = leftmost) of message code.
    // Messages: 0 "OPEn", 1 "FAIL", 2 "LOC ", 3 "----".
    function automatic logic [6:0] msg_glyph(input logic [1:0] code, input logic [1:0] pos);
        logic [6:0] g;
        case ({code, pos})
            4'b00_00: g = 7'h40; // O
            4'b00_01: g = 7'h0C; // P
            4'b00_10: g = 7'h06; // E
            4'b00_11: g = 7'h2B; // n
            4'b01_00: g = 7'h0E; // F
            4'b01_01: g = 7'h08; // A
            4'b01_10: g = 7'h79; // I
            4'b01_11: g = 7'h47; // L
            4'b10_00: g = 7'h47; // L
            4'b10_01: g = 7'h40; // O
            4'b10_10: g = 7'h46; // C
            4'b10_11: g = 7'h7F; // space
            4'b11_00: g = 7'h3F; // -
            4'b11_01: g = 7'h3F; // -
            4'b11_10: g = 7'h3F; // -
            4'b11_11: g = 7'h3F; // -
            default:  g = 7'h7F;
        endcase
        return g;
    endfunction

    // Free-running slot timer and digit index; never restarted by the FSM.
    always_comb begin
        scan_wrap_s = (scan_q == SCAN_LAST);
        frame_end_s = scan_wrap_s && (k_q == 2'd3);
        if (scan_wrap_s) begin
            scan_d = {SCAN_W{1'b0}};
            k_d    = k_q + 2'd1;
        end else begin
            scan_d = scan_q + SCAN_W'(1'b1);
            k_d    = k_q;
        end
    end

    // Message FSM: a request always wins, including on the final frame end.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (msg_req) begin
                    state_d = ST_MSG;
                    hold_d  = {HOLD_W{1'b0}};
                    code_d  = msg_code;
                    ack_d   = 1'b1;
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_MSG: begin
                if (msg_req) begin
                    state_d = ST_MSG;
                    hold_d  = {HOLD_W{1'b0}};
                    code_d  = msg_code;
                    ack_d   = 1'b1;
                end else if (frame_end_s) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_ENTRY;
                        hold_d  = {HOLD_W{1'b0}};
                    end else begin
                        hold_d  = hold_q + HOLD_W'(1'b1);
                    end
                end else begin
                    state_d = ST_MSG;
                end
            end
            default: begin
                state_d = ST_ENTRY;
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Blink gate: only meaningful while a message is shown.
    always_comb begin
`ifdef DISP_BLINK_EN
        blink_off_s = hold_q[BLINK_SHIFT];
`else
        blink_off_s = 1'b0;
`endif
    end

    // Next digit enable and segment pattern for the current slot and source.
    always_comb begin
        case (k_q)
            2'd0:    nibble_s = entry_data[3:0];
            2'd1:    nibble_s = entry_data[7:4];
            2'd2:    nibble_s = entry_data[11:8];
            2'd3:    nibble_s = entry_data[15:12];
            default: nibble_s = 4'h0;
        endcase
        // Digit k (an[k]) shows message character 3-k, so an[3] is leftmost.
        char_pos_s = 2'd3 - k_q;
        an_d       = ~(4'b0001 << k_q);
        if (state_q == ST_MSG) begin
            seg_d = msg_glyph(code_q, char_pos_s);
            if (blink_off_s) begin
                an_d = 4'b1111;
            end else begin
                an_d = ~(4'b0001 << k_q);
            end
        end else if (entry_blank[k_q]) begin
            seg_d = SEG_OFF;
        end else begin
            seg_d = hex_glyph(nibble_s);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            scan_q  <= {SCAN_W{1'b0}};
            k_q     <= 2'd0;
            hold_q  <= {HOLD_W{1'b0}};
            code_q  <= 2'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            ack_q   <= ack_d;
            busy_q  <= (state_d == ST_MSG);
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= 1'b1;
        end
    end

    assign msg_ack = ack_q;
    assign busy    = busy_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_disp_arbiter
// Scoreboard bench for disp_arbiter (SCAN_DIV=4, HOLD_FRAMES=3, BLINK_SHIFT=0).
// A reference model derives every output from the cycle count since reset
// and the message rules; glyphs are built from lists of lit segment letters.
// ---------------------------------------------------------------------------
module tb_disp_arbiter;

    localparam int SD    = 4;
    localparam int HF    = 3;
    localparam int BS    = 0;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] entry_data = 16'h1234;
    logic [3:0]  entry_blank = 4'b0000;
    logic        msg_req = 1'b0;
    logic [1:0]  msg_code = 2'd0;
    logic        msg_ack;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // model state
    int t = 0;
    bit in_msg = 1'b0;
    int mcode = 0;
    int frames_done = 0;
    int final_preempts = 0;

    logic [13:0] exp_q[$];

    disp_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF), .BLINK_SHIFT(BS)) dut (
        .clk(clk), .reset(reset), .entry_data(entry_data), .entry_blank(entry_blank),
        .msg_req(msg_req), .msg_code(msg_code), .msg_ack(msg_ack), .busy(busy),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Active-low pattern from a list of lit segment letters a..g.
    function automatic logic [6:0] segs_of(input string s);
        logic [6:0] m;
        m = 7'h7F;
        for (int i = 0; i < s.len(); i++) begin
            m[int'(s[i]) - 97] = 1'b0;
        end
        return m;
    endfunction

    function automatic string hex_segs(input int v);
        case (v)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
            4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
            8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";  15: return "aefg";
            default: return "";
        endcase
    endfunction

    function automatic byte msg_char(input int code, input int pos);
        string m;
        case (code)
            0: m = "OPEn";
            1: m = "FAIL";
            2: m = "LOC ";
            default: m = "----";
        endcase
        return m[pos];
    endfunction

    function automatic string char_segs(input byte c);
        case (c)
            "O": return "abcdef";
            "P": return "abefg";
            "E": return "adefg";
            "n": return "ceg";
            "F": return "aefg";
            "A": return "abcefg";
            "I": return "bc";
            "L": return "def";
            "C": return "adef";
            "-": return "g";
            default: return "";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts the outputs after each rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = 0;
            in_msg = 1'b0;
            mcode = 0;
            frames_done = 0;
            exp_q.delete();
        end else begin : model_step
            int k;
            bit fe;
            bit dark;
            logic [3:0] an_e;
            logic [6:0] seg_e;
            k = (t / SD) % 4;
            fe = ((t % FRAME) == FRAME - 1);
            dark = 1'b0;
`ifdef DISP_BLINK_EN
            dark = in_msg && (((frames_done >> BS) & 1) == 1);
`endif
            an_e = dark ? 4'b1111 : ~(4'b0001 << k);
            if (in_msg)
                seg_e = segs_of(char_segs(msg_char(mcode, 3 - k)));
            else if (entry_blank[k])
                seg_e = 7'h7F;
            else
                seg_e = segs_of(hex_segs(int'((entry_data >> (4 * k)) & 16'h000F)));
            if (msg_req) begin
                if (in_msg && fe && frames_done == HF - 1) final_preempts++;
                in_msg = 1'b1;
                mcode = int'(msg_code);
                frames_done = 0;
            end else if (in_msg && fe) begin
                frames_done++;
                if (frames_done == HF) begin
                    in_msg = 1'b0;
                    frames_done = 0;
                end
            end
            exp_q.push_back({msg_req, in_msg, 1'b1, an_e, seg_e});
            t++;
        end
    end

    // Monitor: compares the DUT outputs with the oldest prediction.
    always @(negedge clk) begin : monitor
        logic [13:0] act;
        logic [13:0] exp;
        act = {msg_ack, busy, dp, an, seg};
        if (reset || exp_q.size() == 0)
            exp = {1'b0, 1'b0, 1'b1, 4'b1111, 7'h7F};
        else
            exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL outputs at %0t: got ack=%b busy=%b dp=%b an=%b seg=%h expected ack=%b busy=%b dp=%b an=%b seg=%h",
                     $time, act[13], act[12], act[11], act[10:7], act[6:0],
                     exp[13], exp[12], exp[11], exp[10:7], exp[6:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [1:0] code);
        msg_req = 1'b1;
        msg_code = code;
        tick();
        msg_req = 1'b0;
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        tick();
        #1 chk("an_first_slot", {28'd0, an}, 32'h0000000E);
        chk("seg_first_slot", {25'd0, seg}, {25'd0, segs_of("bcfg")});
        cyc(2 * FRAME);
        entry_blank = 4'b0101;
        cyc(FRAME);
        entry_blank = 4'b0000;

        // single message, then return to entry view
        pulse(2'd0);
        #1 chk("ack_after_req", {31'd0, msg_ack}, 32'd1);
        chk("busy_after_req", {31'd0, busy}, 32'd1);
        tick();
        #1 chk("ack_one_cycle", {31'd0, msg_ack}, 32'd0);
        cyc(4 * FRAME);
        chk("back_to_entry", {31'd0, busy}, 32'd0);

        // preempt after two frames
        pulse(2'd2);
        begin
            int n = 0;
            while (!(in_msg && frames_done == 2) && n < 10 * FRAME) begin tick(); n++; end
            chk("reach_frame2", {31'd0, (in_msg && frames_done == 2)}, 32'd1);
        end
        pulse(2'd1);
        cyc(2 * FRAME);
        #1 chk("busy_after_preempt", {31'd0, busy}, 32'd1);
        cyc(2 * FRAME);

        // request on the final frame end edge
        pulse(2'd2);
        begin
            int n = 0;
            while (!(in_msg && frames_done == HF - 1 && (t % FRAME) == FRAME - 1) && n < 10 * FRAME) begin
                tick(); n++;
            end
            chk("reach_final_edge", {31'd0, (in_msg && frames_done == HF - 1 && (t % FRAME) == FRAME - 1)}, 32'd1);
        end
        pulse(2'd3);
        #1 chk("final_edge_ack", {31'd0, msg_ack}, 32'd1);
        chk("final_edge_busy", {31'd0, busy}, 32'd1);
        chk("final_edge_seen", final_preempts, 32'd1);
        cyc(FRAME);

        // held request re-acks every cycle
        msg_req = 1'b1;
        msg_code = 2'd1;
        cyc(5);
        msg_req = 1'b0;
        cyc(FRAME + 3);

        // reset in the middle of a message
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_an", {28'd0, an}, 32'h0000000F);
        chk("rst_seg", {25'd0, seg}, 32'h0000007F);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, msg_ack}, 32'd0);
        cyc(2);
        reset = 1'b0;
        tick();
        #1 chk("entry_after_rst", {27'd0, busy, an}, 32'h0000000E);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                msg_req = 1'b1;
                msg_code = 2'($urandom_range(0, 3));
            end else begin
                msg_req = 1'b0;
            end
            if ($urandom_range(0, 99) < 10) entry_data = 16'($urandom);
            if ($urandom_range(0, 99) < 5) entry_blank = 4'($urandom);
            tick();
        end
        msg_req = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, clk cycles per digit slot (min 2).
REQ-002 SHALL have parameter HOLD_FRAMES, default 500, scan frames a message stays on the display (min 1).
REQ-003 SHALL have parameter BLINK_SHIFT, default 6, hold-counter bit used for the blink phase (used only with DISP_BLINK_EN).
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port entry_data  in  16  four hex digits from the entry FSM; nibble k belongs to digit k.
REQ-007 SHALL have port entry_blank  in  4  bit k=1 blanks digit k in ENTRY view.
REQ-008 SHALL have port msg_req  in  1  level request to show a status message.
REQ-009 SHALL have port msg_code  in  2  message select: 0 "OPEn", 1 "FAIL", 2 "LOC ", 3 "----".
REQ-010 SHALL have port msg_ack  out  1  one-cycle pulse confirming msg_code was latched.
REQ-011 SHALL have port busy  out  1  high while in MSG_SHOW.
REQ-012 SHALL have port an  out  4  digit enables, active-low; an[3] is the leftmost digit.
REQ-013 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port dp  out  1  decimal point, active-low; held at 1 (off).

Function
REQ-015 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit index k SHALL advance 0->1->2->3->0. One frame = 4*SCAN_DIV cycles.
REQ-016 an and seg SHALL be registered; they SHALL reflect index k and current source one cycle after k changes. Exactly one an bit is low, an[k]=0, except when blanked.
REQ-017 FSM SHALL have two states: ENTRY and MSG_SHOW.
REQ-018 ENTRY: seg SHALL show hex glyph 0-F of entry_data[4k+3:4k], read live each slot. entry_blank[k]=1 SHALL give seg=7'h7F.
REQ-019 ENTRY and msg_req=1 at a clk edge: latch msg_code, clear hold counter, enter MSG_SHOW. msg_ack=1 for exactly the next cycle.
REQ-020 MSG_SHOW: seg SHALL show character (3-k) of the latched message on digit k. Characters are left to right on an[3]..an[0]. entry_data is ignored but not stored.
REQ-021 MSG_SHOW and msg_req=1: preempt. Relatch msg_code, clear hold counter, pulse msg_ack, stay in MSG_SHOW. A request held high re-acks every cycle.
REQ-022 Hold counter SHALL increment at each frame end (k=3 slot wrap) in MSG_SHOW.
REQ-023 Frame end with hold counter = HOLD_FRAMES-1 and msg_req=0: return to ENTRY and clear busy the same edge.
REQ-024 Frame end and msg_req=1 on the same edge: msg_req SHALL win (preempt per REQ-021, no return to ENTRY).
REQ-025 Scan counter and digit index SHALL free-run and SHALL NOT restart on state changes. The message starts at the current slot.
REQ-026 busy SHALL equal (state==MSG_SHOW), registered with the state.

Reset
REQ-027 Asynchronous reset SHALL force: state ENTRY, scan counter 0, k=0, hold counter 0, latched code 0, an=4'b1111, seg=7'h7F, dp=1, msg_ack=0, busy=0.
REQ-028 Reset asserted mid-message SHALL drop the message with no msg_ack. After release, the first slot is k=0 in ENTRY.

Configuration
REQ-029 With macro DISP_BLINK_EN defined, MSG_SHOW SHALL force an=4'b1111 while hold_counter[BLINK_SHIFT]=1. Counting and scanning continue.
REQ-030 Without DISP_BLINK_EN, the message SHALL display steadily. Hold counter width SHALL be sized from HOLD_FRAMES only, and BLINK_SHIFT is unused.

Verification (SCAN_DIV=4, HOLD_FRAMES=3, BLINK_SHIFT=0)
REQ-031 Reset, then release: an=1110 from cycle 1 and an sequence 1110,1101,1011,0111 every 4 cycles. entry_data=16'h1234, entry_blank=0 gives seg glyphs 4,3,2,1 on an[0..3].
REQ-032 Pulse msg_req=1, msg_code=0 for one cycle: msg_ack=1 for exactly one cycle after the edge and busy=1. Display reads "OPEn" left to right. Return to ENTRY after 3 frame ends, with busy=0 on that edge.
REQ-033 During MSG_SHOW after 2 frames, pulse msg_req with code 1: "FAIL" is shown and busy stays 1 for 3 further frame ends.
REQ-034 msg_req rises on the same edge as the final frame end: state stays MSG_SHOW, msg_ack=1, hold counter=0.
REQ-035 Assert reset mid-message: an=1111, seg=7F, busy=0 and msg_ack=0 immediately. ENTRY view resumes after release.
REQ-036 With DISP_BLINK_EN: an=1111 for the whole of odd hold frames. Without it: an never reads 1111 in MSG_SHOW.
